// File: rtl/lcu_spg_adder4.sv
// lcu_spg_adder4: registered 4-bit carry-lookahead adder slice (spg cells + lcu)
module lcu_spg_adder4_spg (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic p_o,
  output logic g_o,
  output logic s_o
);
  assign p_o = a_i ^ b_i;
  assign g_o = a_i & b_i;
  assign s_o = p_o ^ c_i;
endmodule

module lcu_spg_adder4_lcu (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       c_i,
  output logic [3:1] c_o,
  output logic       pg_o,
  output logic       gg_o,
  output logic       cout_o
);
  // Flat two-level sum-of-products for every carry; nothing ripples through the cells.
  always_comb begin
    c_o[1] = g_i[0] | (p_i[0] & c_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c_i);
    pg_o   = &p_i;
    gg_o   = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    cout_o = gg_o | (pg_o & c_i);
  end
endmodule

module lcu_spg_adder4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cIn,
  output logic       out_valid,
  output logic [3:0] s,
  output logic       cOut,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g, sum;
  logic [3:0] c;
  logic       pg_c, gg_c, cout_c;
  logic [3:0] s_d, s_q;
  logic       cout_d, cout_q, pg_d, pg_q, gg_d, gg_q, valid_q;
  assign c[0] = cIn;
  for (genvar i = 0; i < 4; i++) begin : g_spg
    lcu_spg_adder4_spg u_spg (
      .a_i(a[i]),
      .b_i(b[i]),
      .c_i(c[i]),
      .p_o(p[i]),
      .g_o(g[i]),
      .s_o(sum[i])
    );
  end
  lcu_spg_adder4_lcu u_lcu (
    .p_i   (p),
    .g_i   (g),
    .c_i   (cIn),
    .c_o   (c[3:1]),
    .pg_o  (pg_c),
    .gg_o  (gg_c),
    .cout_o(cout_c)
  );
  // Capture a fresh result on a valid beat, otherwise hold so unknown idle operands never leak out.
  always_comb begin
    s_d    = in_valid ? sum    : s_q;
    cout_d = in_valid ? cout_c : cout_q;
    pg_d   = in_valid ? pg_c   : pg_q;
    gg_d   = in_valid ? gg_c   : gg_q;
  end
  // Output register; reset wins over in_valid and drops any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      pg_q    <= 1'b0;
      gg_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      pg_q    <= pg_d;
      gg_q    <= gg_d;
      valid_q <= in_valid;
    end
  end
  assign s         = s_q;
  assign cOut      = cout_q;
  assign pg        = pg_q;
  assign gg        = gg_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_lcu_spg_adder4.sv
// tb_lcu_spg_adder4: directed + exhaustive + random checks against an arithmetic reference model
module tb_lcu_spg_adder4;
  logic       clk = 1'b0;
  logic       reset, in_valid, cIn;
  logic [3:0] a, b;
  logic       out_valid, cOut, pg, gg;
  logic [3:0] s;
  int total = 0;
  int bad = 0;
  logic [3:0] m_s;
  logic       m_c, m_pg, m_gg, m_v;

  always #5 clk = ~clk;

  lcu_spg_adder4 dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cIn      (cIn),
    .out_valid(out_valid),
    .s        (s),
    .cOut     (cOut),
    .pg       (pg),
    .gg       (gg)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".s"},     s,                 m_s);
    chk({tag, ".cout"},  {3'b0, cOut},      {3'b0, m_c});
    chk({tag, ".pg"},    {3'b0, pg},        {3'b0, m_pg});
    chk({tag, ".gg"},    {3'b0, gg},        {3'b0, m_gg});
    chk({tag, ".valid"}, {3'b0, out_valid}, {3'b0, m_v});
  endtask

  // One clock: drive at negedge, update the model at the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [3:0] ai, input logic [3:0] bi,
                      input logic ci);
    logic [4:0] t;
    @(negedge clk);
    reset = r; in_valid = v; a = ai; b = bi; cIn = ci;
    @(posedge clk);
    if (r) begin
      m_s = 4'h0; m_c = 1'b0; m_pg = 1'b0; m_gg = 1'b0; m_v = 1'b0;
    end else if (v) begin
      t = 5'(ai) + 5'(bi) + 5'(ci);
      {m_c, m_s} = t;
      m_pg = ((ai ^ bi) == 4'hF);
      m_gg = (5'(ai) + 5'(bi)) >= 5'd16;
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cIn = 1'b0;
    step(1, 0, 4'h0, 4'h0, 0);
    step(1, 0, 4'h0, 4'h0, 0);
    chk_model("reset");
    chk("reset.s_const", s, 4'h0);

    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++) begin
          step(0, 1, 4'(ai), 4'(bi), 1'(ci));
          chk_model("exh");
          chk("exh.excl", {3'b0, pg & gg}, 4'h0);
        end

    step(0, 1, 4'hF, 4'h0, 1);
    chk_model("prop1");
    chk("prop1.sc", {cOut, pg, gg, 1'b0}, 4'b1100);
    step(0, 1, 4'hF, 4'h0, 0);
    chk_model("prop0");
    chk("prop0.s", s, 4'hF);

    step(0, 1, 4'h8, 4'h8, 0);
    chk_model("gen88");
    chk("gen88.sc", {cOut, pg, gg, 1'b0}, 4'b1010);
    step(0, 1, 4'h9, 4'h7, 0);
    chk_model("gen97");
    chk("gen97.s", s, 4'h0);

    step(0, 1, 4'h3, 4'h4, 0);
    chk_model("hold.load");
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 4'($urandom), 4'($urandom), 1'($urandom));
      chk_model("hold");
      chk("hold.s7", s, 4'h7);
    end

    step(0, 1, 4'h6, 4'h6, 1);
    chk_model("pre_rst");
    step(1, 1, 4'hF, 4'hF, 1);
    chk_model("rst_mid");
    chk("rst_mid.s", s, 4'h0);
    step(0, 1, 4'h5, 4'hA, 1);
    chk_model("rst_rel");
    chk("rst_rel.sc", {cOut, pg, out_valid, 1'b0}, 4'b1110);

    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 1'($urandom));
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
